// File: rtl/apb_pkg.sv
// Shared definitions for the APB round-robin master.
// Contents:
//   APB_ADDR_W / APB_DATA_W : default bus widths
//   apb_state_e             : transfer FSM encoding (IDLE, SETUP, ACCESS)
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter producing a one-hot grant.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_req          : per-requester request lines
//   i_en           : grant enable; o_grant is 0 while low
//   i_update       : accept pulse; moves priority past the current winner
//   o_grant        : one-hot grant (combinational)
// The pointer holds the index searched first. Reset sets it to 0, so
// requester 0 has the highest priority right after reset.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  input  logic               i_update,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W:0]   sum_a;
  logic [PTR_W:0]   sum_b;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    o_grant = '0;
    ptr_d   = ptr_q;
    sum_a   = '0;
    sum_b   = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // idx = (ptr + i) mod NUM_REQ without a divider.
      sum_a = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      if (sum_a >= (PTR_W + 1)'(NUM_REQ)) begin
        sum_a = sum_a - (PTR_W + 1)'(NUM_REQ);
      end
      idx = sum_a[PTR_W-1:0];
      if (!found && i_en && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        sum_b        = {1'b0, idx} + 1'b1;
        if (sum_b >= (PTR_W + 1)'(NUM_REQ)) begin
          sum_b = '0;
        end
        ptr_d = sum_b[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (i_update) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB3 master shared by NUM_REQ requesters through round-robin arbitration.
// Ports:
//   i_clk, i_rst_n             : clock, synchronous active-low reset
//   i_req_valid/write/addr/wdata : packed per-requester request fields
//   o_req_ready                : one-hot accept strobe (combinational, IDLE only)
//   o_rsp_valid/rdata/err      : registered one-cycle completion to the granted requester
//   o_paddr/psel/penable/pwrite/pwdata, i_prdata/pready/pslverr : APB3 bus
// Handshake: a request on lane k is taken in the cycle where
// i_req_valid[k] & o_req_ready[k] is 1. The requester keeps valid, write,
// addr and wdata steady until then. o_rsp_valid has no back-pressure.
// TIMEOUT bounds the ACCESS phase in cycles (0 = unbounded); an expired
// transfer completes with err=1 and rdata=0.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic [ADDR_W-1:0]         o_paddr,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [DATA_W-1:0]         o_pwdata,
  input  logic [DATA_W-1:0]         i_prdata,
  input  logic                      i_pready,
  input  logic                      i_pslverr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_e         state_q;
  apb_state_e         state_d;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] grant_q;
  logic               accept;
  logic               done;
  logic               tmo;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_write;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req_valid),
    .i_en     (state_q == ST_IDLE),
    .i_update (accept),
    .o_grant  (grant)
  );

  // The grant only ever covers valid lanes, so any grant bit is an accept.
  assign o_req_ready = grant;
  assign accept      = |grant;

  // One-hot select of the winning request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_addr  = sel_addr  | i_req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | i_req_wdata[k*DATA_W +: DATA_W];
        sel_write = sel_write | i_req_write[k];
      end
    end
  end

  // Next state and bus strobes. pready wins over a timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    tmo       = 1'b0;
    o_psel    = 1'b0;
    o_penable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        o_psel  = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        o_psel    = 1'b1;
        o_penable = 1'b1;
        if (i_pready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done    = 1'b1;
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      cnt_q       <= '0;
      o_paddr     <= '0;
      o_pwrite    <= 1'b0;
      o_pwdata    <= '0;
      o_rsp_valid <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_rsp_valid <= '0;
      if (accept) begin
        o_paddr  <= sel_addr;
        o_pwrite <= sel_write;
        o_pwdata <= sel_wdata;
        grant_q  <= grant;
        cnt_q    <= '0;
      end
      if (state_q == ST_ACCESS && !done) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (done) begin
        o_rsp_valid <= grant_q;
        o_rsp_rdata <= (tmo || o_pwrite) ? '0 : i_prdata;
        o_rsp_err   <= tmo | i_pslverr;
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
module tb_apb_rr_master;

  localparam int N       = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [N-1:0]    i_req_valid = '0;
  logic [N-1:0]    i_req_write = '0;
  logic [N*AW-1:0] i_req_addr  = '0;
  logic [N*DW-1:0] i_req_wdata = '0;
  logic [N-1:0]    o_req_ready;
  logic [N-1:0]    o_rsp_valid;
  logic [DW-1:0]   o_rsp_rdata;
  logic            o_rsp_err;
  logic [AW-1:0]   o_paddr;
  logic            o_psel;
  logic            o_penable;
  logic            o_pwrite;
  logic [DW-1:0]   o_pwdata;
  logic [DW-1:0]   i_prdata  = '0;
  logic            i_pready  = 1'b0;
  logic            i_pslverr = 1'b0;

  apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_paddr(o_paddr), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwrite(o_pwrite), .o_pwdata(o_pwdata),
    .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave plans (per requester) ----------------
  int          p_wait [N];
  bit          p_stuck[N];
  logic [31:0] p_rdata[N];
  bit          p_err  [N];

  task automatic set_plan(input int k, input int w, input bit stuck, input logic [31:0] rd, input bit err);
    p_wait[k] = w; p_stuck[k] = stuck; p_rdata[k] = rd; p_err[k] = err;
  endtask

  // Plan of the transfer currently on the bus, latched at accept.
  int          s_wait  = 0;
  bit          s_stuck = 1'b0;
  logic [31:0] s_rdata = '0;
  bit          s_err   = 1'b0;
  int          acnt    = 0;

  // APB slave: answers after s_wait extra ACCESS cycles; drives noise otherwise.
  always @(negedge i_clk) begin
    if (o_psel === 1'b1 && o_penable === 1'b1) begin
      if (!s_stuck && acnt == s_wait) begin
        i_pready = 1'b1; i_prdata = s_rdata; i_pslverr = s_err;
      end else begin
        i_pready = 1'b0; i_prdata = 32'hBAD0BAD0; i_pslverr = 1'b1;
      end
      acnt++;
    end else begin
      acnt = 0; i_pready = 1'b0; i_prdata = 32'hBAD0BAD0; i_pslverr = 1'b0;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit   started = 1'b0;
  logic rst_q   = 1'b0;
  always @(posedge i_clk) begin
    started <= 1'b1;
    rst_q   <= i_rst_n;
  end

  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_tacc = 0, m_tend = 0, m_g = 0, m_ptr = 0;
  logic [31:0] m_paddr = '0, m_pwdata = '0;
  logic        m_pwrite = 1'b0;
  logic [DW:0] exp_q[$];
  int          pen_cnt = 0;

  int          obs_acc_cyc[$], obs_acc_idx[$];
  int          obs_rsp_cyc[$], obs_rsp_idx[$], obs_pen[$];
  logic [31:0] obs_rsp_rdata[$];
  logic        obs_rsp_err[$];

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int ptr);
    logic [N-1:0] g;
    bit found;
    g = '0; found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (!found && v[k]) begin g[k] = 1'b1; found = 1'b1; end
    end
    return g;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge i_clk) begin
    if (started) begin
      logic [N-1:0] e_ready, e_rsp;
      logic         e_psel, e_pen;
      logic [DW:0]  e_data;
      int           len;
      cyc++;
      if (!rst_q) begin
        m_busy = 1'b0; m_ptr = 0; m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
        exp_q.delete(); pen_cnt = 0;
        chk("rst_rdata", o_rsp_rdata, 0);
        chk("rst_err", o_rsp_err, 0);
      end
      e_psel = m_busy && cyc > m_tacc && cyc < m_tend;
      e_pen  = m_busy && cyc >= m_tacc + 2 && cyc < m_tend;
      e_rsp  = '0;
      if (m_busy && cyc == m_tend) e_rsp[m_g] = 1'b1;
      chk("psel", o_psel, e_psel);
      chk("penable", o_penable, e_pen);
      chk("rsp_valid", o_rsp_valid, e_rsp);
      chk("paddr", o_paddr, m_paddr);
      chk("pwrite", o_pwrite, m_pwrite);
      chk("pwdata", o_pwdata, m_pwdata);
      if (o_penable === 1'b1) pen_cnt++;
      if (o_rsp_valid != '0) begin
        obs_rsp_cyc.push_back(cyc); obs_rsp_idx.push_back(oh_idx(o_rsp_valid));
        obs_rsp_rdata.push_back(o_rsp_rdata); obs_rsp_err.push_back(o_rsp_err);
        obs_pen.push_back(pen_cnt);
      end
      if (e_rsp != '0) begin
        e_data = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("rsp_payload", {o_rsp_err, o_rsp_rdata}, e_data);
        m_busy = 1'b0;
      end
      e_ready = m_busy ? '0 : rr_pick(i_req_valid, m_ptr);
      chk("req_ready", o_req_ready, e_ready);
      if ((o_req_ready & i_req_valid) != '0) begin
        obs_acc_cyc.push_back(cyc); obs_acc_idx.push_back(oh_idx(o_req_ready));
        pen_cnt = 0;
      end
      if (e_ready != '0 && i_rst_n) begin
        m_g = oh_idx(e_ready); m_busy = 1'b1; m_tacc = cyc; m_ptr = (m_g + 1) % N;
        m_paddr  = i_req_addr[m_g*AW +: AW];
        m_pwdata = i_req_wdata[m_g*DW +: DW];
        m_pwrite = i_req_write[m_g];
        s_wait = p_wait[m_g]; s_stuck = p_stuck[m_g]; s_rdata = p_rdata[m_g]; s_err = p_err[m_g];
        if (p_stuck[m_g] || p_wait[m_g] + 1 > TIMEOUT) begin
          len = TIMEOUT; e_data = {1'b1, 32'h0};
        end else begin
          len = p_wait[m_g] + 1;
          e_data = {p_err[m_g], (m_pwrite ? 32'h0 : p_rdata[m_g])};
        end
        m_tend = cyc + 2 + len;
        exp_q.push_back(e_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic wait_acc(input int target);
    for (int c = 0; c < 100 && obs_acc_idx.size() < target; c++) tick();
    chk("accept_in_time", obs_acc_idx.size() >= target, 1);
  endtask

  task automatic wait_rsp(input int target);
    for (int c = 0; c < 100 && obs_rsp_idx.size() < target; c++) tick();
    chk("rsp_in_time", obs_rsp_idx.size() >= target, 1);
  endtask

  task automatic set_req(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    i_req_write[k] = wr;
    i_req_addr[k*AW +: AW] = addr;
    i_req_wdata[k*DW +: DW] = wd;
  endtask

  task automatic do_req(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    n = obs_acc_idx.size();
    set_req(k, wr, addr, wd);
    i_req_valid[k] = 1'b1;
    wait_acc(n + 1);
    i_req_valid[k] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int na, nr;
    for (int k = 0; k < N; k++) set_plan(k, 0, 0, 32'h0, 0);
    i_rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_psel", o_psel, 0);
    chk("reset_rsp_valid", o_rsp_valid, 0);
    chk("reset_paddr", o_paddr, 0);
    i_rst_n = 1'b1;
    tick();

    // 1: zero-wait write from requester 0
    set_plan(0, 0, 0, 32'h1111_2222, 0);
    na = obs_acc_idx.size(); nr = obs_rsp_idx.size();
    do_req(0, 1, 32'h10, 32'hDEADBEEF);
    chk("t1_setup_psel", o_psel, 1);
    chk("t1_setup_penable", o_penable, 0);
    chk("t1_paddr", o_paddr, 32'h10);
    chk("t1_pwrite", o_pwrite, 1);
    chk("t1_pwdata", o_pwdata, 32'hDEADBEEF);
    wait_rsp(nr + 1);
    chk("t1_grant", obs_acc_idx[na], 0);
    chk("t1_latency", obs_rsp_cyc[nr] - obs_acc_cyc[na], 3);
    chk("t1_rsp_idx", obs_rsp_idx[nr], 0);
    chk("t1_err", obs_rsp_err[nr], 0);
    chk("t1_rdata", obs_rsp_rdata[nr], 0);
    chk("t1_penable_cycles", obs_pen[nr], 1);

    // 2: read from requester 1 with 3 wait states
    set_plan(1, 3, 0, 32'h12345678, 0);
    na = obs_acc_idx.size(); nr = obs_rsp_idx.size();
    do_req(1, 0, 32'h20, 32'h0);
    wait_rsp(nr + 1);
    chk("t2_grant", obs_acc_idx[na], 1);
    chk("t2_penable_cycles", obs_pen[nr], 4);
    chk("t2_latency", obs_rsp_cyc[nr] - obs_acc_cyc[na], 6);
    chk("t2_rsp_idx", obs_rsp_idx[nr], 1);
    chk("t2_rdata", obs_rsp_rdata[nr], 32'h12345678);
    chk("t2_err", obs_rsp_err[nr], 0);

    // 3: both requesters held -> strict alternation, one accept per 3 cycles
    set_plan(0, 0, 0, 32'hAAAA0000, 0);
    set_plan(1, 0, 0, 32'hBBBB0000, 0);
    set_req(0, 0, 32'h100, 32'h0);
    set_req(1, 0, 32'h104, 32'h0);
    na = obs_acc_idx.size(); nr = obs_rsp_idx.size();
    i_req_valid = 2'b11;
    wait_acc(na + 4);
    i_req_valid = 2'b00;
    wait_rsp(nr + 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant_order", obs_acc_idx[na+i], i % 2);
      chk("t3_rdata", obs_rsp_rdata[nr+i], (i % 2 == 0) ? 32'hAAAA0000 : 32'hBBBB0000);
      if (i > 0) chk("t3_accept_period", obs_acc_cyc[na+i] - obs_acc_cyc[na+i-1], 3);
    end

    // 4: slave never ready -> timeout after 16 ACCESS cycles, then normal service
    set_plan(0, 0, 1, 32'h0, 0);
    na = obs_acc_idx.size(); nr = obs_rsp_idx.size();
    do_req(0, 0, 32'h40, 32'h0);
    wait_rsp(nr + 1);
    chk("t4_penable_cycles", obs_pen[nr], 16);
    chk("t4_latency", obs_rsp_cyc[nr] - obs_acc_cyc[na], 18);
    chk("t4_err", obs_rsp_err[nr], 1);
    chk("t4_rdata", obs_rsp_rdata[nr], 0);
    chk("t4_bus_idle", o_psel, 0);
    set_plan(1, 1, 0, 32'hCAFEF00D, 0);
    nr = obs_rsp_idx.size();
    do_req(1, 0, 32'h44, 32'h0);
    wait_rsp(nr + 1);
    chk("t4_next_err", obs_rsp_err[nr], 0);
    chk("t4_next_rdata", obs_rsp_rdata[nr], 32'hCAFEF00D);
    chk("t4_next_penable_cycles", obs_pen[nr], 2);

    // 5: slave error on a write
    set_plan(0, 0, 0, 32'h5555AAAA, 1);
    nr = obs_rsp_idx.size();
    do_req(0, 1, 32'h30, 32'h0BADF00D);
    wait_rsp(nr + 1);
    chk("t5_err", obs_rsp_err[nr], 1);
    chk("t5_rdata", obs_rsp_rdata[nr], 0);
    chk("t5_rsp_idx", obs_rsp_idx[nr], 0);

    // 6: reset during ACCESS (pointer currently favours requester 1)
    set_plan(1, 0, 1, 32'h0, 0);
    do_req(1, 0, 32'h50, 32'h0);
    repeat (4) tick();
    chk("t6_in_access", o_penable, 1);
    i_rst_n = 1'b0;
    tick();
    chk("t6_psel_dropped", o_psel, 0);
    chk("t6_penable_dropped", o_penable, 0);
    chk("t6_no_rsp", o_rsp_valid, 0);
    i_rst_n = 1'b1;
    nr = obs_rsp_idx.size();
    repeat (3) tick();
    chk("t6_no_late_rsp", obs_rsp_idx.size(), nr);
    set_plan(0, 0, 0, 32'h0000600D, 0);
    set_plan(1, 0, 0, 32'h00007777, 0);
    set_req(0, 0, 32'h60, 32'h0);
    set_req(1, 0, 32'h64, 32'h0);
    na = obs_acc_idx.size();
    i_req_valid = 2'b11;
    wait_acc(na + 1);
    i_req_valid[0] = 1'b0;
    chk("t6_first_after_reset", obs_acc_idx[na], 0);
    wait_acc(na + 2);
    i_req_valid[1] = 1'b0;
    chk("t6_second_after_reset", obs_acc_idx[na+1], 1);
    wait_rsp(nr + 2);
    chk("t6_rdata0", obs_rsp_rdata[nr], 32'h0000600D);
    chk("t6_rdata1", obs_rsp_rdata[nr+1], 32'h00007777);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Synthesizable APB3 master that shares one APB bus between NUM_REQ requesters, e.g. host command port and TPU weight/config loader.
- Arbitrates with round-robin, runs the SETUP/ACCESS sequence, honours i_pready/i_pslverr, and returns read data or error to the granted requester.
- Bounds each transfer with an ACCESS-phase timeout.
- Sits between the TPU control logic and the APB register slaves (systolic array config, buffers).

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles before forced termination; 0 disables the timeout.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_write  in  NUM_REQ  1=write, 0=read.
- i_req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W].
- i_req_wdata  in  NUM_REQ*DATA_W  packed write data.
- o_req_ready  out  NUM_REQ  one-hot accept strobe.
- o_rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- o_rsp_rdata  out  DATA_W  read data; valid with o_rsp_valid.
- o_rsp_err  out  1  pslverr or timeout; valid with o_rsp_valid.
- o_paddr  out  ADDR_W  APB address.
- o_psel  out  1  APB select.
- o_penable  out  1  APB enable.
- o_pwrite  out  1  APB direction.
- o_pwdata  out  DATA_W  APB write data.
- i_prdata  in  DATA_W  APB read data.
- i_pready  in  1  slave ready.
- i_pslverr  in  1  slave error.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - State goes to IDLE and the RR pointer to 0, so requester 0 has highest priority.
  - All APB outputs, o_rsp_*, and the timeout counter go to 0.
  - Reset mid-transfer aborts immediately: psel/penable drop next cycle and no o_rsp_valid is issued.
- o_req_ready is combinational: one-hot grant while state==IDLE, 0 in all other states.
  - A request is accepted in the cycle where valid&ready=1.
  - Requesters hold valid, addr, write and wdata stable until accepted.
- Round robin: the search starts at (last_grant+1) mod NUM_REQ. last_grant updates on accept.
- FSM states:
  - IDLE: on accept, latch addr/write/wdata/grant into o_paddr/o_pwrite/o_pwdata and go to SETUP.
  - SETUP: psel=1, penable=0. Go to ACCESS unconditionally.
  - ACCESS: psel=1, penable=1. Counter increments each cycle.
    - If i_pready=1, sample i_prdata (reads) and i_pslverr, then go to IDLE.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1, force completion with err=1, rdata=0, then go to IDLE.
- Completion (registered):
  - In the cycle after completion, o_rsp_valid[grant]=1 for exactly one cycle, with o_rsp_rdata and o_rsp_err.
  - o_rsp_rdata=0 for writes.
  - psel and penable return to 0 in that same cycle.
- o_paddr, o_pwdata and o_pwrite hold their last values in IDLE.
- Latency: accept at cycle T, SETUP at T+1, ACCESS at T+2. With zero wait states, rsp_valid is at T+3 and the next accept may also happen at T+3. Minimum period is 3 cycles per transfer.
- A request asserted in the same cycle as a completion is accepted in that cycle only if state is already IDLE; no bypass path.
- Error does not stall the arbiter.
- The timeout counter clears on entry to SETUP.

Decomposition:
- Shared package apb_pkg holds:
  - FSM state encoding localparams: ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2.
  - Default ADDR_W/DATA_W constants.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin grant. Inputs are request, enable and the update pulse; output is the one-hot grant.
- The FSM and APB drive stay in apb_rr_master.

Test Plan:
1. Reset hold, then req0 write addr=0x10 data=0xDEADBEEF with pready tied 1 -> ready0 at T; psel T+1..T+2; penable T+2; pwrite=1, paddr=0x10; rsp_valid[0] at T+3 with err=0.
2. req1 read addr=0x20, slave returns 0x12345678 after 3 wait states -> penable held 4 cycles; o_rsp_rdata=0x12345678 with rsp_valid[1].
3. req0 and req1 held continuously -> grants alternate 0,1,0,1 with one accept every 3 cycles; no starvation.
4. TIMEOUT=16, pready stuck 0 -> ACCESS lasts exactly 16 cycles; rsp_err=1, rdata=0; bus idle the next cycle; next request then served normally.
5. Slave returns pslverr=1 on a write to 0x30 -> rsp_err=1 with rsp_valid.
6. Reset asserted during ACCESS -> psel=penable=0 after that edge, no rsp_valid, RR pointer back to 0 so requester 0 is served first.
